read_fifo_sched: RTL and testbench

READ_FIFO_SCHED -- requirements
Module: read_fifo_sched

---
 rtl/read_fifo_sched_pkg.sv | 18 +
 rtl/read_fifo_sched_frame_word_cnt.sv | 33 +++
 rtl/read_fifo_sched.sv | 144 ++++++++++++++
 tb/tb_read_fifo_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_fifo_sched_pkg.sv
// Shared constants and types for the dual-FIFO frame reader.
package read_fifo_sched_pkg;

    localparam int FRAME_LEN_DEF = 1000;
    localparam int DATA_W_DEF    = 16;
    localparam int CNT_W_DEF     = 10;

    localparam logic SEL_FIFO_1 = 1'b0;
    localparam logic SEL_FIFO_2 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/read_fifo_sched_frame_word_cnt.sv
// Per-frame word counter: clear on load, step on each issued read, flags first/last word.
module frame_word_cnt
    import read_fifo_sched_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic first,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign first = (count == '0);
    assign last  = (count == LAST_IDX);

endmodule

// File: rtl/read_fifo_sched.sv
// Ping-pong frame reader: drains whichever FIFO has filled, one FRAME_LEN-word frame at a
// time, paced by proc_ready, with frame markers and a sticky underrun flag.
module read_fifo_sched
    import read_fifo_sched_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdfull_1,
    input  logic              rdfull_2,
    input  logic              rdempty_1,
    input  logic              rdempty_2,
    input  logic [DATA_W-1:0] q_1,
    input  logic [DATA_W-1:0] q_2,
    input  logic              proc_ready,
    output logic              rdreq_1,
    output logic              rdreq_2,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_sel,
    output logic              underrun_err
);

    sched_state_t state, state_nxt;

    logic last_sel;
    logic sel_nxt;
    logic sel_empty;
    logic rd_issue;
    logic cnt_load;
    logic cnt_first;
    logic cnt_last;
    logic abort;
    logic valid_q;
    logic start_q;
    logic end_q;

    frame_word_cnt #(
        .CNT_W     (CNT_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .inc   (rd_issue),
        .first (cnt_first),
        .last  (cnt_last)
    );

    assign sel_empty = (frame_sel == SEL_FIFO_2) ? rdempty_2 : rdempty_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = frame_sel;
        rd_issue  = 1'b0;
        cnt_load  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rdfull_1 || rdfull_2) begin
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                cnt_load = 1'b1;
                if (rdfull_1 && rdfull_2) begin
                    sel_nxt   = ~last_sel;
                    state_nxt = ST_READ;
                end else if (rdfull_1) begin
                    sel_nxt   = SEL_FIFO_1;
                    state_nxt = ST_READ;
                end else if (rdfull_2) begin
                    sel_nxt   = SEL_FIFO_2;
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                // READ is left on the last issued word, so the counter is always below FRAME_LEN here
                if (sel_empty) begin
                    abort     = 1'b1;
                    state_nxt = ST_FLUSH;
                end else if (proc_ready) begin
                    rd_issue = 1'b1;
                    if (cnt_last) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sel    <= SEL_FIFO_1;
            last_sel     <= SEL_FIFO_2;
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            frame_sel <= sel_nxt;
            valid_q   <= rd_issue;
            start_q   <= rd_issue && cnt_first;
            end_q     <= rd_issue && cnt_last;
            if (abort) begin
                underrun_err <= 1'b1;
            end
            if (state == ST_FLUSH) begin
                last_sel <= frame_sel;
            end
        end
    end

    assign rdreq_1     = rd_issue && (frame_sel == SEL_FIFO_1);
    assign rdreq_2     = rd_issue && (frame_sel == SEL_FIFO_2);
    assign data_valid  = valid_q;
    assign frame_start = start_q;
    // Abort marks the word already in flight this cycle, or stands alone if none
    assign frame_end   = end_q | abort;
    // FIFO q is itself registered, so it is presented in the cycle after rdreq and gated by valid
    assign data_out    = valid_q ? ((frame_sel == SEL_FIFO_2) ? q_2 : q_1) : '0;

endmodule

// File: tb/tb_read_fifo_sched.sv
// Self-checking bench: behavioural FIFOs plus a frame-level reference of the expected word stream.
module tb_read_fifo_sched;
    import read_fifo_sched_pkg::*;

    localparam int FL = 4;
    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdfull_1, rdfull_2, rdempty_1, rdempty_2;
    logic [DW-1:0] q_1 = '0;
    logic [DW-1:0] q_2 = '0;
    logic          proc_ready;
    logic          rdreq_1, rdreq_2;
    logic [DW-1:0] data_out;
    logic          data_valid, frame_start, frame_end, frame_sel, underrun_err;

    read_fifo_sched #(
        .FRAME_LEN (FL),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdfull_1     (rdfull_1),
        .rdfull_2     (rdfull_2),
        .rdempty_1    (rdempty_1),
        .rdempty_2    (rdempty_2),
        .q_1          (q_1),
        .q_2          (q_2),
        .proc_ready   (proc_ready),
        .rdreq_1      (rdreq_1),
        .rdreq_2      (rdreq_2),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .frame_sel    (frame_sel),
        .underrun_err (underrun_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic          sel;
    } obs_t;

    // FIFO models: tasks write mem/wr, the read process owns rd
    logic [DW-1:0] mem1 [512];
    logic [DW-1:0] mem2 [512];
    int unsigned   wr1 = 0, wr2 = 0, rd1 = 0, rd2 = 0;
    logic          full_force1 = 1'b0;
    int unsigned   pop_empty = 0;

    always @(posedge clk) begin
        if (rdreq_1) begin
            if (wr1 == rd1) pop_empty++;
            else begin q_1 <= mem1[rd1 % 512]; rd1 <= rd1 + 1; end
        end
        if (rdreq_2) begin
            if (wr2 == rd2) pop_empty++;
            else begin q_2 <= mem2[rd2 % 512]; rd2 <= rd2 + 1; end
        end
    end

    always_comb begin
        rdempty_1 = (wr1 == rd1);
        rdempty_2 = (wr2 == rd2);
        rdfull_1  = ((wr1 - rd1) >= FL) || full_force1;
        rdfull_2  = ((wr2 - rd2) >= FL);
    end

    logic rand_ready = 1'b0, ready_rnd = 1'b1, ready_fix = 1'b1;
    assign proc_ready = rand_ready ? ready_rnd : ready_fix;
    always @(posedge clk) begin
        #2;
        ready_rnd = 1'($urandom_range(0, 1));
    end

    // Monitor samples on the falling edge
    obs_t        obs[$];
    int unsigned rdq_cyc[$], val_cyc[$];
    int unsigned cyc = 0, both_cnt = 0, nrdy_cnt = 0, end_alone = 0;

    always @(negedge clk) begin
        cyc++;
        if (rdreq_1 && rdreq_2) both_cnt++;
        if ((rdreq_1 || rdreq_2) && !proc_ready) nrdy_cnt++;
        if (rdreq_1 || rdreq_2) rdq_cyc.push_back(cyc);
        if (data_valid) begin
            obs.push_back({data_out, frame_start, frame_end, frame_sel});
            val_cyc.push_back(cyc);
        end else if (frame_end) begin
            end_alone++;
        end
    end

    int   checks = 0, errors = 0;
    obs_t exp_q[$];
    int unsigned er1 = 0, er2 = 0;
    logic model_last = 1'b1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic src, input int n);
        for (int i = 0; i < n; i++) begin
            if (src) begin mem2[(wr2 + i) % 512] = DW'($urandom); end
            else     begin mem1[(wr1 + i) % 512] = DW'($urandom); end
        end
        if (src) wr2 += n; else wr1 += n;
    endtask

    // Reference: a frame of n words drawn in order from the chosen FIFO
    task automatic expect_frame(input logic src, input int n);
        obs_t o;
        for (int k = 0; k < n; k++) begin
            o.d   = src ? mem2[er2 % 512] : mem1[er1 % 512];
            o.s   = (k == 0);
            o.e   = (k == n - 1);
            o.sel = src;
            exp_q.push_back(o);
            if (src) er2++; else er1++;
        end
        model_last = src;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_last = 1'b1;
        er1 = rd1;
        er2 = rd2;
        exp_q.delete();
    endtask

    task automatic wait_words(input int base, input int n);
        for (int i = 0; i < 400 && (obs.size() - base) < n; i++) tick();
        repeat (6) tick();
    endtask

    task automatic run_rounds(input int base, input int rounds);
        logic [1:0] pat;
        logic       first;
        for (int r = 0; r < rounds; r++) begin
            pat = (r == 0) ? 2'd3 : 2'($urandom_range(1, 3));
            if (pat[0]) push(1'b0, FL);
            if (pat[1]) push(1'b1, FL);
            if (pat == 2'd3) begin
                first = ~model_last;
                expect_frame(first, FL);
                expect_frame(~first, FL);
            end else begin
                expect_frame(pat == 2'd2, FL);
            end
            wait_words(base, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready_fix = 1'b1;
        tick();
        tick();
        checks++;
        if ({rdreq_1, rdreq_2, data_valid, frame_start, frame_end} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rdreq_1, rdreq_2, data_valid, frame_start, frame_end});
        end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
        checks++;
        if (frame_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", frame_sel); end
        checks++;
        if (underrun_err !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int base, rb, vb, ok;
        do_reset();
        base = obs.size(); rb = rdq_cyc.size(); vb = val_cyc.size();
        push(1'b0, FL);
        expect_frame(1'b0, FL);
        wait_words(base, FL);
        checks++;
        if (obs.size() - base !== FL) begin errors++; $display("FAIL single_count: got %0d expected %0d", obs.size() - base, FL); end
        for (int k = 0; k < FL && base + k < obs.size(); k++) begin
            checks++;
            if (obs[base + k] !== exp_q[k]) begin
                errors++; $display("FAIL single_word%0d: got %h expected %h", k, obs[base + k], exp_q[k]);
            end
        end
        checks++;
        if (rdq_cyc.size() - rb !== FL || rdq_cyc[rb + FL - 1] - rdq_cyc[rb] !== FL - 1) begin
            errors++; $display("FAIL single_rdreq_run: got %0d reads expected %0d contiguous", rdq_cyc.size() - rb, FL);
        end
        ok = 1;
        for (int k = 0; k < FL && vb + k < val_cyc.size() && rb + k < rdq_cyc.size(); k++)
            if (val_cyc[vb + k] !== rdq_cyc[rb + k] + 1) ok = 0;
        checks++;
        if (ok !== 1) begin errors++; $display("FAIL single_latency: got mismatch expected valid 1 cycle after rdreq"); end
    endtask

    task automatic test_arbitration();
        int base, bc;
        do_reset();
        base = obs.size(); bc = both_cnt;
        run_rounds(base, 4);
        checks++;
        if (obs.size() - base !== exp_q.size()) begin errors++; $display("FAIL arb_count: got %0d expected %0d", obs.size() - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < obs.size(); k++) begin
            checks++;
            if (obs[base + k] !== exp_q[k]) begin
                errors++; $display("FAIL arb_word%0d: got %h expected %h", k, obs[base + k], exp_q[k]);
            end
        end
        checks++;
        if (both_cnt !== bc) begin errors++; $display("FAIL arb_both_rdreq: got %0d cycles expected 0", both_cnt - bc); end
    endtask

    task automatic test_proc_ready();
        int base, nb;
        do_reset();
        base = obs.size(); nb = nrdy_cnt;
        rand_ready = 1'b1;
        run_rounds(base, 3);
        rand_ready = 1'b0;
        checks++;
        if (obs.size() - base !== exp_q.size()) begin errors++; $display("FAIL ready_count: got %0d expected %0d", obs.size() - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < obs.size(); k++) begin
            checks++;
            if (obs[base + k] !== exp_q[k]) begin
                errors++; $display("FAIL ready_word%0d: got %h expected %h", k, obs[base + k], exp_q[k]);
            end
        end
        checks++;
        if (nrdy_cnt !== nb) begin errors++; $display("FAIL ready_gating: got %0d reads while not ready expected 0", nrdy_cnt - nb); end
    endtask

    task automatic test_underrun();
        int base, ea;
        do_reset();
        ea = end_alone;
        base = obs.size();
        full_force1 = 1'b1;
        tick();
        tick();
        full_force1 = 1'b0;
        repeat (5) tick();
        checks++;
        if (end_alone - ea !== 1 || obs.size() !== base) begin
            errors++; $display("FAIL underrun_alone: got %0d lone ends %0d words expected 1 and 0", end_alone - ea, obs.size() - base);
        end
        checks++;
        if (underrun_err !== 1'b1) begin errors++; $display("FAIL underrun_alone_flag: got %b expected 1", underrun_err); end

        do_reset();
        base = obs.size();
        push(1'b0, 2);
        full_force1 = 1'b1;
        expect_frame(1'b0, 2);
        for (int i = 0; i < 100 && obs.size() == base; i++) tick();
        full_force1 = 1'b0;
        wait_words(base, 2);
        checks++;
        if (underrun_err !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b expected 1", underrun_err); end
        push(1'b1, FL);
        expect_frame(1'b1, FL);
        wait_words(base, exp_q.size());
        checks++;
        if (obs.size() - base !== exp_q.size()) begin errors++; $display("FAIL underrun_count: got %0d expected %0d", obs.size() - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < obs.size(); k++) begin
            checks++;
            if (obs[base + k] !== exp_q[k]) begin
                errors++; $display("FAIL underrun_word%0d: got %h expected %h", k, obs[base + k], exp_q[k]);
            end
        end
        checks++;
        if (underrun_err !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun_err); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        base = obs.size();
        push(1'b0, FL);
        for (int i = 0; i < 100 && (obs.size() - base) < 2; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({rdreq_1, rdreq_2, data_valid, frame_start, frame_end, frame_sel, underrun_err} !== 7'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b data %h expected all 0",
                     {rdreq_1, rdreq_2, data_valid, frame_start, frame_end, frame_sel, underrun_err}, data_out);
        end
        rst = 1'b0;
        model_last = 1'b1;
        er1 = rd1;
        er2 = rd2;
        exp_q.delete();
        tick();
        base = obs.size();
        push(1'b0, FL);
        expect_frame(1'b0, FL);
        wait_words(base, FL);
        checks++;
        if (obs.size() - base !== FL) begin errors++; $display("FAIL midreset_count: got %0d expected %0d", obs.size() - base, FL); end
        for (int k = 0; k < FL && base + k < obs.size(); k++) begin
            checks++;
            if (obs[base + k] !== exp_q[k]) begin
                errors++; $display("FAIL midreset_word%0d: got %h expected %h", k, obs[base + k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_arbitration();
        test_proc_ready();
        test_underrun();
        test_reset_mid_frame();
        checks++;
        if (pop_empty !== 0) begin errors++; $display("FAIL read_while_empty: got %0d expected 0", pop_empty); end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL both_rdreq_total: got %0d expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
